// File: rtl/pe_act_receiver_pkg.sv
// Shared types for the PE activation receiver: bus widths, FSM encoding and
// the queue-entry layout (activation index in the MSBs, value in the LSBs).
package pe_act_receiver_pkg;

  localparam int unsigned PE_ACT_NO_W = 16;
  localparam int unsigned PE_ADDR_W   = 16;
  localparam int unsigned PE_DATA_W   = 16;
  localparam int unsigned PE_QUEUE_W  = PE_ADDR_W + PE_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } recv_state_e;

  typedef struct packed {
    logic [PE_ADDR_W-1:0] idx;
    logic [PE_DATA_W-1:0] val;
  } act_entry_t;

endpackage

// File: rtl/pe_skid_buffer.sv
// Two-entry FIFO skid buffer between the router flit port and the PE
// activation queue; a push and pop in the same cycle keep occupancy.
module pe_skid_buffer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full,
  output logic [1:0]   count_next
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + 2'(do_push) - 2'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign empty      = (count_q == 2'd0);
  assign full       = (count_q == 2'd2);
  assign count_next = count_d;

endmodule

// File: rtl/pe_act_receiver.sv
// Receives activation flits from the router and forwards them to the PE queue.
// Define PE_ZERO_SKIP_EN to count but not forward zero-valued activations.
module pe_act_receiver
  import pe_act_receiver_pkg::*;
#(
  parameter int unsigned PE_IDX = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pe_start_calc,
  input  logic [PE_ACT_NO_W-1:0] in_act_no,
  input  logic                  act_recv_en,
  input  logic [PE_ADDR_W-1:0]  act_recv_idx,
  input  logic [PE_DATA_W-1:0]  act_recv_data,
  output logic                  recv_rdy,
  input  logic                  queue_full,
  output logic                  push_act,
  output logic [PE_QUEUE_W-1:0] act_in,
  output logic                  layer_recv_done
);

  recv_state_e            state_q, state_d;
  logic [PE_ACT_NO_W-1:0] cnt_q, cnt_d;
  logic [PE_ACT_NO_W-1:0] act_no_q, act_no_d;
  logic                   recv_rdy_q, recv_rdy_d;
  logic                   done_q, done_d;

  logic                   accept;
  logic                   buf_wr;
  logic                   buf_pop;
  logic                   buf_empty;
  logic                   buf_full;
  logic [1:0]             buf_cnt_next;
  logic [PE_QUEUE_W-1:0]  buf_head;
  act_entry_t             wr_entry;

  assign accept   = act_recv_en && recv_rdy_q;
  assign wr_entry = '{idx: act_recv_idx, val: act_recv_data};

`ifdef PE_ZERO_SKIP_EN
  assign buf_wr = accept && (act_recv_data != '0);
`else
  assign buf_wr = accept;
`endif

  assign buf_pop = !buf_empty && !queue_full;

  pe_skid_buffer #(
    .W(PE_QUEUE_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (buf_wr),
    .push_data  (wr_entry),
    .pop        (buf_pop),
    .head       (buf_head),
    .empty      (buf_empty),
    .full       (buf_full),
    .count_next (buf_cnt_next)
  );

  // Layer sequencing; the received count includes flits that were not stored.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_no_d   = act_no_q;
    recv_rdy_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pe_start_calc) begin
          act_no_d = in_act_no;
          cnt_d    = '0;
          state_d  = (in_act_no == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        if (accept) begin
          cnt_d = cnt_q + PE_ACT_NO_W'(1);
          if (cnt_q == act_no_q - PE_ACT_NO_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (buf_cnt_next == 2'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    recv_rdy_d = (state_d == ST_RECV) && (buf_cnt_next < 2'd2);
    done_d     = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      act_no_q   <= '0;
      recv_rdy_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_no_q   <= act_no_d;
      recv_rdy_q <= recv_rdy_d;
      done_q     <= done_d;
    end
  end

  assign recv_rdy        = recv_rdy_q;
  assign push_act        = buf_pop;
  assign act_in          = buf_head;
  assign layer_recv_done = done_q;

`ifndef SYNTHESIS
  // Out-of-range indices are forwarded untouched but flagged here.
  idx_range_a : assert property (@(posedge clk) disable iff (rst)
    accept |-> (act_recv_idx < act_no_q))
    else $error("pe_act_receiver[%0d]: act_recv_idx %0d >= in_act_no %0d",
                PE_IDX, act_recv_idx, act_no_q);

  no_overflow_a : assert property (@(posedge clk) disable iff (rst)
    !(buf_wr && buf_full && !buf_pop))
    else $error("pe_act_receiver[%0d]: skid buffer overflow", PE_IDX);
`endif

endmodule

// File: tb/tb_pe_act_receiver.sv
// Scoreboard bench for pe_act_receiver: stimulus queues expected pushes,
// a negedge monitor pops and compares every push_act.
module tb_pe_act_receiver;
  import pe_act_receiver_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   pe_start_calc;
  logic [PE_ACT_NO_W-1:0] in_act_no;
  logic                   act_recv_en;
  logic [PE_ADDR_W-1:0]   act_recv_idx;
  logic [PE_DATA_W-1:0]   act_recv_data;
  logic                   recv_rdy;
  logic                   queue_full;
  logic                   push_act;
  logic [PE_QUEUE_W-1:0]  act_in;
  logic                   layer_recv_done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int accepted = 0;
  logic [PE_QUEUE_W-1:0] exp_q[$];
  logic [PE_QUEUE_W-1:0] exp_v;

  always #5 clk = ~clk;

  pe_act_receiver #(.PE_IDX(0)) dut (
    .clk             (clk),
    .rst             (rst),
    .pe_start_calc   (pe_start_calc),
    .in_act_no       (in_act_no),
    .act_recv_en     (act_recv_en),
    .act_recv_idx    (act_recv_idx),
    .act_recv_data   (act_recv_data),
    .recv_rdy        (recv_rdy),
    .queue_full      (queue_full),
    .push_act        (push_act),
    .act_in          (act_in),
    .layer_recv_done (layer_recv_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every push must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && push_act) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_push: got act_in 0x%0h, required no push", act_in);
      end else begin
        exp_v = exp_q.pop_front();
        check("push_data", 64'(act_in), 64'(exp_v));
      end
    end
    if (!rst && layer_recv_done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic [PE_ACT_NO_W-1:0] n);
    pe_start_calc = 1'b1;
    in_act_no     = n;
    tick(1);
    pe_start_calc = 1'b0;
  endtask

  task automatic send_flit(input logic [PE_ADDR_W-1:0] idx, input logic [PE_DATA_W-1:0] d,
                           input bit expect_push);
    bit ok = 1'b0;
    act_recv_en   = 1'b1;
    act_recv_idx  = idx;
    act_recv_data = d;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (recv_rdy) ok = 1'b1;
      @(posedge clk);
    end
    #1;
    act_recv_en = 1'b0;
    if (ok) begin
      accepted++;
      if (expect_push) exp_q.push_back({idx, d});
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: flit idx %0d not accepted, required accept within 60 cycles", idx);
    end
  endtask

  task automatic wait_done(input int base, input string name);
    int i = 0;
    while (done_cnt == base && i < 60) begin
      @(negedge clk);
      i++;
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    check({name, "_done_once"}, 64'(done_cnt), 64'(base + 1));
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc_base;
    bit push_exp;
    logic [PE_DATA_W-1:0] zs_data [4];
    zs_data[0] = 16'd0; zs_data[1] = 16'd9; zs_data[2] = 16'd0; zs_data[3] = 16'd3;

    rst = 1'b1; pe_start_calc = 1'b0; in_act_no = '0; act_recv_en = 1'b0;
    act_recv_idx = '0; act_recv_data = '0; queue_full = 1'b0;
    tick(2);
    check("rst_recv_rdy", 64'(recv_rdy), 64'(0));
    check("rst_push_act", 64'(push_act), 64'(0));
    check("rst_act_in", 64'(act_in), 64'(0));
    check("rst_done", 64'(layer_recv_done), 64'(0));
    rst = 1'b0;
    tick(2);

    // Four back-to-back flits: pushes on the four cycles after each accept.
    base = done_cnt;
    start_layer(16'd4);
    fork
      begin
        send_flit(16'd0, 16'd5, 1'b1);
        send_flit(16'd1, 16'd6, 1'b1);
        send_flit(16'd2, 16'd7, 1'b1);
        send_flit(16'd3, 16'd8, 1'b1);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check("b2b_push_timing", 64'(push_act), 64'((i >= 1 && i <= 4) ? 1 : 0));
        end
      end
    join
    wait_done(base, "b2b");

    // Queue back-pressure: two accepts fill the buffer, third flit is held.
    base = done_cnt;
    acc_base = accepted;
    queue_full = 1'b1;
    start_layer(16'd3);
    fork
      begin
        send_flit(16'd0, 16'd11, 1'b1);
        send_flit(16'd1, 16'd12, 1'b1);
        send_flit(16'd2, 16'd13, 1'b1);
      end
      begin
        repeat (10) @(negedge clk);
        check("bp_accepted", 64'(accepted - acc_base), 64'(2));
        check("bp_recv_rdy", 64'(recv_rdy), 64'(0));
        check("bp_push_act", 64'(push_act), 64'(0));
        @(posedge clk);
        #1;
        queue_full = 1'b0;
      end
    join
    wait_done(base, "bp");

    // Empty layer: done two cycles after start, never ready, no push.
    base = done_cnt;
    start_layer(16'd0);
    @(negedge clk);
    check("zero_done_c1", 64'(layer_recv_done), 64'(0));
    check("zero_rdy_c1", 64'(recv_rdy), 64'(0));
    @(negedge clk);
    check("zero_done_c2", 64'(layer_recv_done), 64'(1));
    check("zero_rdy_c2", 64'(recv_rdy), 64'(0));
    @(negedge clk);
    check("zero_done_c3", 64'(layer_recv_done), 64'(0));
    @(posedge clk);
    #1;
    check("zero_done_once", 64'(done_cnt), 64'(base + 1));

    // Zero-valued activations: skipped only when the feature is built in.
    base = done_cnt;
    start_layer(16'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef PE_ZERO_SKIP_EN
      push_exp = (zs_data[i] != '0);
`else
      push_exp = 1'b1;
`endif
      send_flit(PE_ADDR_W'(i), zs_data[i], push_exp);
    end
    wait_done(base, "zskip");

    // Reset mid-layer with buffered flits: everything discarded.
    queue_full = 1'b1;
    start_layer(16'd4);
    send_flit(16'd0, 16'd21, 1'b0);
    send_flit(16'd1, 16'd22, 1'b0);
    #1;
    rst = 1'b1;
    queue_full = 1'b0;
    #1;
    check("midrst_recv_rdy", 64'(recv_rdy), 64'(0));
    check("midrst_push_act", 64'(push_act), 64'(0));
    check("midrst_act_in", 64'(act_in), 64'(0));
    check("midrst_done", 64'(layer_recv_done), 64'(0));
    tick(1);
    rst = 1'b0;
    base = done_cnt;
    tick(5);
    check("midrst_no_done", 64'(done_cnt), 64'(base));
    start_layer(16'd2);
    send_flit(16'd0, 16'd31, 1'b1);
    send_flit(16'd1, 16'd32, 1'b1);
    wait_done(base, "postrst");

    // Start re-pulsed mid-layer is ignored; done only after the 4th flit.
    base = done_cnt;
    start_layer(16'd4);
    send_flit(16'd0, 16'd41, 1'b1);
    send_flit(16'd1, 16'd42, 1'b1);
    start_layer(16'd4);
    send_flit(16'd2, 16'd43, 1'b1);
    @(negedge clk);
    check("restart_no_early_done", 64'(done_cnt), 64'(base));
    @(posedge clk);
    #1;
    send_flit(16'd3, 16'd44, 1'b1);
    wait_done(base, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_act_receiver.md
PE_ACT_RECEIVER -- requirements
Module: pe_act_receiver

Interface
REQ-001 Parameter PE_IDX, default 0, PE index used only in simulation messages and assertions.
REQ-002 clk  input  1  system clock; all flops on rising edge.
REQ-003 rst  input  1  system reset, asynchronous, active-high.
REQ-004 pe_start_calc  input  1  start of a layer; arms reception.
REQ-005 in_act_no  input  `PeActNoBus  number of input activations expected this layer.
REQ-006 act_recv_en  input  1  router delivers a valid activation flit this cycle.
REQ-007 act_recv_idx  input  `PeAddrBus  global input activation index carried by the flit.
REQ-008 act_recv_data  input  `PeDataBus  activation value carried by the flit.
REQ-009 recv_rdy  output  1  receiver can accept a flit this cycle; registered.
REQ-010 queue_full  input  1  PE activation queue cannot accept a push.
REQ-011 push_act  output  1  push one entry into the activation queue.
REQ-012 act_in  output  `PEQueueBus  queue entry {act_recv_idx, act_recv_data}, index in the MSBs.
REQ-013 layer_recv_done  output  1  one-cycle pulse when all in_act_no flits are received and forwarded.

Function
REQ-014 A flit is accepted only in a cycle where act_recv_en and recv_rdy are both 1; act_recv_en while recv_rdy=0 is ignored and the router holds the flit.
REQ-015 States: IDLE, RECV, DRAIN, DONE; encoding 2 bits, IDLE=0.
REQ-016 IDLE -> RECV on pe_start_calc when in_act_no>0; IDLE -> DONE on pe_start_calc when in_act_no=0.
REQ-017 RECV -> DRAIN on the cycle that accepts flit number in_act_no (counter = in_act_no-1 at acceptance).
REQ-018 DRAIN -> DONE when the skid buffer is empty (including the cycle its last entry is pushed).
REQ-019 DONE asserts layer_recv_done for exactly one cycle, then -> IDLE.
REQ-020 pe_start_calc in RECV, DRAIN or DONE is ignored.
REQ-021 Received counter is `PeActNoBus wide, cleared on entry to RECV, incremented per accepted flit (dropped flits included, see REQ-030); it never wraps within a layer.
REQ-022 Accepted flits enter a 2-entry FIFO skid buffer; recv_rdy = (next state is RECV) and (buffer occupancy after this cycle < 2).
REQ-023 push_act = buffer non-empty and !queue_full; act_in = buffer head; a push pops the head the same cycle.
REQ-024 Minimum latency: flit accepted at cycle N appears on push_act at cycle N+1.
REQ-025 Simultaneous accept and push: occupancy unchanged, order preserved (strict FIFO).
REQ-026 Buffer full and queue_full: recv_rdy=0 next cycle, no data lost or duplicated.
REQ-027 act_recv_idx >= in_act_no is forwarded unchanged; a simulation-only assertion flags it.

Reset
REQ-028 On rst: state IDLE, counter 0, buffer empty; recv_rdy=0, push_act=0, act_in=0, layer_recv_done=0.
REQ-029 Reset mid-layer discards buffered flits; no push or done pulse occurs until a new pe_start_calc.

Configuration
REQ-030 Macro PE_ZERO_SKIP_EN defined: accepted flits with act_recv_data=0 are counted but not written to the buffer, never pushed; undefined: every accepted flit is pushed.

Structure
REQ-031 State encodings and the act_in field split (index/value offsets) live in shared pe.vh alongside `PEQueueBus.
REQ-032 Skid buffer is sub-module pe_skid_buffer (2 entries, width `PEQueueBus, push/pop/empty/full); FSM and counter stay in pe_act_receiver.

Verification
REQ-033 in_act_no=4, flits idx 0..3 data 5,6,7,8 back-to-back, queue_full=0 -> four pushes in order, cycles N+1..N+4, one layer_recv_done pulse after the last push.
REQ-034 in_act_no=3, queue_full=1 held 10 cycles while 3 flits offered -> recv_rdy drops after 2 accepts, 3rd flit held; on release pushes idx 0,1,2 exactly once.
REQ-035 in_act_no=0, pe_start_calc -> layer_recv_done pulses 2 cycles later, no push, recv_rdy stays 0.
REQ-036 PE_ZERO_SKIP_EN defined, in_act_no=4, data 0,9,0,3 -> pushes only (1,9),(3,3); done pulse still fires; undefined -> 4 pushes.
REQ-037 rst asserted after 2 of 4 flits with buffer non-empty -> all outputs 0 same cycle; new pe_start_calc with in_act_no=2 -> exactly 2 pushes and one done.
REQ-038 pe_start_calc re-pulsed mid-RECV with in_act_no=4 -> ignored; counter continues, done after 4th flit.
